// File: rtl/cpu_mem_arbiter_pkg.sv
// rtl/cpu_mem_arbiter_pkg.sv - shared CPU definitions for the inst/data memory arbiter
package cpu_mem_arbiter_pkg;

  localparam int CPU_ADDR_W = 32;
  localparam int CPU_DATA_W = 32;
  localparam int CPU_SIZE_W = 2;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } arb_owner_e;

  // Data is preferred; inst only wins alone or once it has been starved long enough.
  function automatic logic inst_wins(input logic inst_req, input logic data_req,
                                     input logic starved);
    return inst_req && (!data_req || starved);
  endfunction

endpackage

// File: rtl/cpu_mem_arbiter.sv
// rtl/cpu_mem_arbiter.sv - two-port SRAM-like arbiter (inst/data) onto one memory port
// One transaction in flight: IDLE grants, ADDR presents to memory, RESP returns data.
module cpu_mem_arbiter
  import cpu_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = CPU_ADDR_W,
  parameter int DATA_W     = CPU_DATA_W,
  parameter int STARVE_MAX = 2
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  inst_req,
  input  logic                  inst_wr,
  input  logic [CPU_SIZE_W-1:0] inst_size,
  input  logic [ADDR_W-1:0]     inst_addr,
  input  logic [DATA_W/8-1:0]   inst_wstrb,
  input  logic [DATA_W-1:0]     inst_wdata,
  output logic                  inst_addr_ok,
  output logic                  inst_data_ok,
  output logic [DATA_W-1:0]     inst_rdata,

  input  logic                  data_req,
  input  logic                  data_wr,
  input  logic [CPU_SIZE_W-1:0] data_size,
  input  logic [ADDR_W-1:0]     data_addr,
  input  logic [DATA_W/8-1:0]   data_wstrb,
  input  logic [DATA_W-1:0]     data_wdata,
  output logic                  data_addr_ok,
  output logic                  data_data_ok,
  output logic [DATA_W-1:0]     data_rdata,

  output logic                  mem_req,
  output logic                  mem_wr,
  output logic [CPU_SIZE_W-1:0] mem_size,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W/8-1:0]   mem_wstrb,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_addr_ok,
  input  logic                  mem_data_ok,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  arb_state_e              r_state;
  arb_state_e              w_state_nxt;
  arb_owner_e              r_owner;
  logic [CNT_W-1:0]        r_starve_cnt;

  logic                    r_wr;
  logic [CPU_SIZE_W-1:0]   r_size;
  logic [ADDR_W-1:0]       r_addr;
  logic [STRB_W-1:0]       r_wstrb;
  logic [DATA_W-1:0]       r_wdata;

  logic                    w_starved;
  logic                    w_inst_win;
  logic                    w_grant;

  assign w_starved  = (r_starve_cnt == CNT_MAX);
  assign w_inst_win = inst_wins(inst_req, data_req, w_starved);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Handshakes are purely combinational so a grant or response costs no extra cycle.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant      = 1'b0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    mem_req      = 1'b0;
    if (!reset) begin
      case (r_state)
        ARB_IDLE: begin
          if (inst_req || data_req) begin
            w_grant      = 1'b1;
            inst_addr_ok = w_inst_win;
            data_addr_ok = !w_inst_win;
            w_state_nxt  = ARB_ADDR;
          end
        end
        ARB_ADDR: begin
          mem_req = 1'b1;
          if (mem_addr_ok) begin
            w_state_nxt = ARB_RESP;
          end
        end
        ARB_RESP: begin
          if (mem_data_ok) begin
            inst_data_ok = (r_owner == OWN_INST);
            data_data_ok = (r_owner == OWN_DATA);
            w_state_nxt  = ARB_IDLE;
          end
        end
        default: begin
          w_state_nxt = ARB_IDLE;
        end
      endcase
    end
  end

  // Request fields are captured only on a grant and otherwise hold their last value.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner      <= OWN_DATA;
      r_starve_cnt <= '0;
      r_wr         <= 1'b0;
      r_size       <= '0;
      r_addr       <= '0;
      r_wstrb      <= '0;
      r_wdata      <= '0;
    end else if (w_grant) begin
      if (w_inst_win) begin
        r_owner      <= OWN_INST;
        r_starve_cnt <= '0;
        r_wr         <= inst_wr;
        r_size       <= inst_size;
        r_addr       <= inst_addr;
        r_wstrb      <= inst_wstrb;
        r_wdata      <= inst_wdata;
      end else begin
        r_owner <= OWN_DATA;
        if (inst_req && !w_starved) begin
          r_starve_cnt <= r_starve_cnt + 1'b1;
        end
        r_wr    <= data_wr;
        r_size  <= data_size;
        r_addr  <= data_addr;
        r_wstrb <= data_wstrb;
        r_wdata <= data_wdata;
      end
    end
  end

  assign mem_wr     = r_wr;
  assign mem_size   = r_size;
  assign mem_addr   = r_addr;
  assign mem_wstrb  = r_wstrb;
  assign mem_wdata  = r_wdata;

  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// tb/tb_cpu_mem_arbiter.sv - self-checking bench for cpu_mem_arbiter
module tb_cpu_mem_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SW   = DW / 8;
  localparam int SMAX = 2;
  localparam logic [31:0] IADDR = 32'h0000_1000;
  localparam logic [31:0] DADDR = 32'h1C00_0040;

  logic clk, reset;
  logic inst_req, inst_wr, inst_addr_ok, inst_data_ok;
  logic [1:0] inst_size;
  logic [AW-1:0] inst_addr;
  logic [SW-1:0] inst_wstrb;
  logic [DW-1:0] inst_wdata, inst_rdata;
  logic data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0] data_size;
  logic [AW-1:0] data_addr;
  logic [SW-1:0] data_wstrb;
  logic [DW-1:0] data_wdata, data_rdata;
  logic mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [1:0] mem_size;
  logic [AW-1:0] mem_addr;
  logic [SW-1:0] mem_wstrb;
  logic [DW-1:0] mem_wdata, mem_rdata;

  cpu_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = IADDR; inst_wstrb = 4'hF; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = DADDR; data_wstrb = 4'hF; data_wdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 32'hDEADBEEF;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    next_cycle();
    reset = 0;
  endtask

  typedef struct packed {
    logic [4:0]  in;    // rst, inst_req, data_req, mem_addr_ok, mem_data_ok
    logic [4:0]  ex;    // inst_addr_ok, data_addr_ok, mem_req, inst_data_ok, data_data_ok
    logic        ca;
    logic [31:0] addr;
  } vec_t;

  function automatic vec_t mk(input logic [4:0] in, input logic [4:0] ex,
                              input logic ca, input logic [31:0] addr);
    vec_t v;
    v.in = in; v.ex = ex; v.ca = ca; v.addr = addr;
    return v;
  endfunction

  vec_t vt[18];

  typedef struct {
    logic own_inst;
    bit   accepted;
  } txn_t;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } lat_t;

  initial begin
    string grants, doks, exp_g;
    int n_dok;
    txn_t q[$];
    lat_t lat, nlat;
    int losses;
    logic e_iaok, e_daok, e_mreq, e_idok, e_ddok, pick_inst;

    vt[0]  = mk(5'b11100, 5'b00000, 1'b0, 32'h0);
    vt[1]  = mk(5'b00000, 5'b00000, 1'b1, 32'h0);
    vt[2]  = mk(5'b00100, 5'b01000, 1'b0, 32'h0);
    vt[3]  = mk(5'b00010, 5'b00100, 1'b1, DADDR);
    vt[4]  = mk(5'b00001, 5'b00001, 1'b0, 32'h0);
    vt[5]  = mk(5'b00001, 5'b00000, 1'b1, DADDR);
    vt[6]  = mk(5'b01000, 5'b10000, 1'b0, 32'h0);
    vt[7]  = mk(5'b00001, 5'b00100, 1'b1, IADDR);
    vt[8]  = mk(5'b00011, 5'b00100, 1'b1, IADDR);
    vt[9]  = mk(5'b00000, 5'b00000, 1'b0, 32'h0);
    vt[10] = mk(5'b00001, 5'b00010, 1'b0, 32'h0);
    vt[11] = mk(5'b00100, 5'b01000, 1'b0, 32'h0);
    vt[12] = mk(5'b00010, 5'b00100, 1'b1, DADDR);
    vt[13] = mk(5'b10001, 5'b00000, 1'b0, 32'h0);
    vt[14] = mk(5'b00001, 5'b00000, 1'b1, 32'h0);
    vt[15] = mk(5'b01000, 5'b10000, 1'b0, 32'h0);
    vt[16] = mk(5'b00010, 5'b00100, 1'b1, IADDR);
    vt[17] = mk(5'b00001, 5'b00010, 1'b0, 32'h0);

    idle_inputs();
    reset = 1;
    for (int i = 0; i < 18; i++) begin
      {reset, inst_req, data_req, mem_addr_ok, mem_data_ok} = vt[i].in;
      @(negedge clk);
      chk($sformatf("vec%0d.inst_addr_ok", i), inst_addr_ok, vt[i].ex[4]);
      chk($sformatf("vec%0d.data_addr_ok", i), data_addr_ok, vt[i].ex[3]);
      chk($sformatf("vec%0d.mem_req", i),      mem_req,      vt[i].ex[2]);
      chk($sformatf("vec%0d.inst_data_ok", i), inst_data_ok, vt[i].ex[1]);
      chk($sformatf("vec%0d.data_data_ok", i), data_data_ok, vt[i].ex[0]);
      if (vt[i].ca) chk($sformatf("vec%0d.mem_addr", i), mem_addr, vt[i].addr);
      if (vt[i].ex[0]) chk($sformatf("vec%0d.data_rdata", i), data_rdata, 32'hDEADBEEF);
      if (vt[i].ex[1]) chk($sformatf("vec%0d.inst_rdata", i), inst_rdata, 32'hDEADBEEF);
      next_cycle();
    end

    // Both ports requesting continuously: starvation guard lets inst in every third grant.
    do_reset();
    inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
    grants = ""; doks = "";
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      if (inst_addr_ok) grants = {grants, "I"};
      if (data_addr_ok) grants = {grants, "D"};
      if (inst_data_ok) doks = {doks, "I"};
      if (data_data_ok) doks = {doks, "D"};
      if (c % 3 != 0) chk($sformatf("both.c%0d.no_grant", c), inst_addr_ok | data_addr_ok, 1'b0);
      next_cycle();
    end
    exp_g = "DDIDDI";
    chk("both.grant_count", grants.len(), 6);
    chk("both.resp_count", doks.len(), 6);
    for (int k = 0; k < 6; k++) begin
      if (k < grants.len()) chk($sformatf("both.grant%0d", k), grants[k], exp_g[k]);
      if (k < doks.len())   chk($sformatf("both.resp%0d", k), doks[k], exp_g[k]);
    end

    // Write transaction.
    do_reset();
    data_req = 1; data_wr = 1; data_wstrb = 4'b0011; data_wdata = 32'h1234;
    data_addr = 32'h1C00_0080; data_size = 2'd1;
    @(negedge clk);
    chk("wr.data_addr_ok", data_addr_ok, 1'b1);
    next_cycle();
    data_req = 0; mem_addr_ok = 1;
    @(negedge clk);
    chk("wr.mem_req", mem_req, 1'b1);
    chk("wr.mem_wr", mem_wr, 1'b1);
    chk("wr.mem_wstrb", mem_wstrb, 4'b0011);
    chk("wr.mem_wdata", mem_wdata, 32'h1234);
    chk("wr.mem_size", mem_size, 2'd1);
    chk("wr.mem_addr", mem_addr, 32'h1C00_0080);
    next_cycle();
    mem_addr_ok = 0; mem_data_ok = 1;
    n_dok = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (data_data_ok) n_dok++;
      chk($sformatf("wr.c%0d.inst_data_ok", c), inst_data_ok, 1'b0);
      next_cycle();
    end
    chk("wr.data_ok_once", n_dok, 1);

    // Stalled downstream: request held stable, no further grants.
    do_reset();
    inst_req = 1; inst_addr = 32'h0000_2000;
    @(negedge clk);
    chk("stall.inst_addr_ok", inst_addr_ok, 1'b1);
    next_cycle();
    data_req = 1; inst_addr = 32'h0000_3000;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("stall.c%0d.mem_req", c), mem_req, 1'b1);
      chk($sformatf("stall.c%0d.mem_addr", c), mem_addr, 32'h0000_2000);
      chk($sformatf("stall.c%0d.addr_ok", c), {inst_addr_ok, data_addr_ok}, 2'b00);
      next_cycle();
    end
    mem_addr_ok = 1;
    @(negedge clk);
    chk("stall.accept.mem_req", mem_req, 1'b1);
    next_cycle();
    mem_addr_ok = 0; mem_data_ok = 1;
    @(negedge clk);
    chk("stall.inst_data_ok", inst_data_ok, 1'b1);
    chk("stall.data_data_ok", data_data_ok, 1'b0);
    next_cycle();
    mem_data_ok = 0;
    @(negedge clk);
    chk("stall.next_grant_data", data_addr_ok, 1'b1);
    next_cycle();

    // Random traffic against a transaction-level reference.
    do_reset();
    q.delete();
    losses = 0;
    lat = '{wr: 0, size: 0, addr: 0, wstrb: 0, wdata: 0};
    for (int c = 0; c < 2000; c++) begin
      reset       = ($urandom_range(0, 99) == 0);
      inst_req    = 1'($urandom_range(0, 1));
      data_req    = 1'($urandom_range(0, 1));
      inst_wr     = 1'($urandom_range(0, 1));
      data_wr     = 1'($urandom_range(0, 1));
      inst_size   = 2'($urandom_range(0, 3));
      data_size   = 2'($urandom_range(0, 3));
      inst_addr   = $urandom;
      data_addr   = $urandom;
      inst_wstrb  = 4'($urandom_range(0, 15));
      data_wstrb  = 4'($urandom_range(0, 15));
      inst_wdata  = $urandom;
      data_wdata  = $urandom;
      mem_addr_ok = 1'($urandom_range(0, 1));
      mem_data_ok = 1'($urandom_range(0, 1));
      mem_rdata   = $urandom;

      e_iaok = 0; e_daok = 0; e_mreq = 0; e_idok = 0; e_ddok = 0; pick_inst = 0;
      nlat = lat;
      if (!reset) begin
        if (q.size() == 0) begin
          if (inst_req || data_req) begin
            pick_inst = inst_req && (!data_req || losses >= SMAX);
            e_iaok = pick_inst;
            e_daok = !pick_inst;
            if (pick_inst)
              nlat = '{wr: inst_wr, size: inst_size, addr: inst_addr, wstrb: inst_wstrb, wdata: inst_wdata};
            else
              nlat = '{wr: data_wr, size: data_size, addr: data_addr, wstrb: data_wstrb, wdata: data_wdata};
          end
        end else if (!q[0].accepted) begin
          e_mreq = 1;
        end else if (mem_data_ok) begin
          e_idok = q[0].own_inst;
          e_ddok = !q[0].own_inst;
        end
      end

      @(negedge clk);
      chk($sformatf("rnd%0d.inst_addr_ok", c), inst_addr_ok, e_iaok);
      chk($sformatf("rnd%0d.data_addr_ok", c), data_addr_ok, e_daok);
      chk($sformatf("rnd%0d.mem_req", c),      mem_req,      e_mreq);
      chk($sformatf("rnd%0d.inst_data_ok", c), inst_data_ok, e_idok);
      chk($sformatf("rnd%0d.data_data_ok", c), data_data_ok, e_ddok);
      chk($sformatf("rnd%0d.mem_wr", c),       mem_wr,       lat.wr);
      chk($sformatf("rnd%0d.mem_size", c),     mem_size,     lat.size);
      chk($sformatf("rnd%0d.mem_addr", c),     mem_addr,     lat.addr);
      chk($sformatf("rnd%0d.mem_wstrb", c),    mem_wstrb,    lat.wstrb);
      chk($sformatf("rnd%0d.mem_wdata", c),    mem_wdata,    lat.wdata);
      if (e_idok) chk($sformatf("rnd%0d.inst_rdata", c), inst_rdata, mem_rdata);
      if (e_ddok) chk($sformatf("rnd%0d.data_rdata", c), data_rdata, mem_rdata);

      if (reset) begin
        q.delete();
        losses = 0;
        lat = '{wr: 0, size: 0, addr: 0, wstrb: 0, wdata: 0};
      end else if (e_iaok || e_daok) begin
        q.push_back('{own_inst: pick_inst, accepted: 1'b0});
        if (pick_inst) losses = 0;
        else if (inst_req) losses = (losses + 1 > SMAX) ? SMAX : losses + 1;
        lat = nlat;
      end else if (e_mreq && mem_addr_ok) begin
        q[0].accepted = 1'b1;
      end else if (e_idok || e_ddok) begin
        void'(q.pop_front());
      end
      next_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
